sdram_mport_arbiter: RTL and testbench

- Parametrised successor to the single-write/single-read SDRAM arbitration path.
- Arbitrates NUM_CH independent client channels, each a read or write burst requester, plus auto-refresh, onto one shared write engine and one shared read engine.
- Issues one-cycle start pulses and holds the selected address and length stable for the whole transaction.
- Sits between the frame-buffer clients (camera write, TFT read, future ports) and the existing init/refresh/write/read sub-blocks.

---
 rtl/sdram_pkg.sv | 25 ++
 rtl/sdram_mport_arbiter_rr_pick.sv | 32 +++
 rtl/sdram_mport_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sdram_mport_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the multi-port SDRAM arbitration path.
// Holds the arbiter state encoding, default bus widths and a width helper.
package sdram_pkg;

  localparam int unsigned DEF_ADDR_W = 24;
  localparam int unsigned DEF_LEN_W  = 10;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_ARB       = 3'd1,
    ST_REFRESH   = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READ      = 3'd4,
    ST_ZDONE     = 3'd5
  } arb_state_e;

  // Bits needed to hold 0..n-1, never less than 1.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/sdram_mport_arbiter_rr_pick.sv
// Rotating priority encoder: first requester strictly after ptr, wrapping.
// Ports: req (request vector), ptr (last winner), grant_c (one-hot winner),
//        idx_c (winner index), any_c (at least one request).
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [PW-1:0] idx_c,
  output logic          any_c
);

  // Walk distances N..1 so the nearest requester after ptr is written last.
  always_comb begin
    int unsigned j;
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    j       = 0;
    for (int unsigned i = N; i >= 1; i--) begin
      j = (32'(ptr) + i) % N;
      if (req[j]) begin
        idx_c = PW'(j);
        any_c = 1'b1;
      end
    end
    if (any_c) grant_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/sdram_mport_arbiter.sv
// Arbitrates NUM_CH burst clients plus auto-refresh onto the shared SDRAM
// write and read engines. Issues one-cycle start pulses and holds the
// granted address/length stable until the next grant.
// Ports: i_sysclk/i_sysrst (clock, sync active-high reset); i_init_done;
//        i_refresh_request/i_refresh_done; i_wr_done/i_rd_done (engine
//        completions); i_ch_req/i_ch_we/i_ch_addr/i_ch_len (packed client
//        requests); o_ch_grant/o_ch_done (per-channel handshake);
//        o_refresh_start/o_write_start/o_read_start (engine starts);
//        o_sel_addr/o_sel_len (latched burst); o_busy; o_err (sticky timeout).
module sdram_mport_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     i_sysclk,
  input  logic                     i_sysrst,
  input  logic                     i_init_done,
  input  logic                     i_refresh_request,
  input  logic                     i_refresh_done,
  input  logic                     i_wr_done,
  input  logic                     i_rd_done,
  input  logic [NUM_CH-1:0]        i_ch_req,
  input  logic [NUM_CH-1:0]        i_ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]  i_ch_len,
  output logic [NUM_CH-1:0]        o_ch_grant,
  output logic [NUM_CH-1:0]        o_ch_done,
  output logic                     o_refresh_start,
  output logic                     o_write_start,
  output logic                     o_read_start,
  output logic [ADDR_W-1:0]        o_sel_addr,
  output logic [LEN_W-1:0]         o_sel_len,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int unsigned PW = idx_width(NUM_CH);
  localparam int unsigned TW = idx_width(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [NUM_CH-1:0]    grant_d, done_d;
  logic                 ref_start_d, wr_start_d, rd_start_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [LEN_W-1:0]     len_d;
  logic                 busy_d, err_d;

  logic [NUM_CH-1:0]    pick_grant;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 eng_done;
  logic                 start_now;

  logic [ADDR_W-1:0]    ch_addr [NUM_CH];
  logic [LEN_W-1:0]     ch_len  [NUM_CH];

  // Unpack the flat client buses.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_addr[g] = i_ch_addr[g*ADDR_W +: ADDR_W];
    assign ch_len[g]  = i_ch_len[g*LEN_W +: LEN_W];
  end

  rr_pick #(.N(NUM_CH), .PW(PW)) u_rr_pick (
    .req     (i_ch_req),
    .ptr     (rr_ptr_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .any_c   (pick_any)
  );

  // Completion from whichever engine owns the current state.
  always_comb begin
    eng_done = 1'b0;
    case (state_q)
      ST_REFRESH: eng_done = i_refresh_done;
      ST_WRITE:   eng_done = i_wr_done;
      ST_READ:    eng_done = i_rd_done;
      default:    eng_done = 1'b0;
    endcase
  end

  // A done seen while its start pulse is still high belongs to nothing.
  assign start_now = o_refresh_start | o_write_start | o_read_start;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tcnt_d      = tcnt_q;
    grant_d     = o_ch_grant;
    done_d      = '0;
    ref_start_d = 1'b0;
    wr_start_d  = 1'b0;
    rd_start_d  = 1'b0;
    addr_d      = o_sel_addr;
    len_d       = o_sel_len;
    err_d       = o_err;

    case (state_q)
      ST_WAIT_INIT: begin
        if (i_init_done) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (i_refresh_request) begin
          state_d     = ST_REFRESH;
          ref_start_d = 1'b1;
          tcnt_d      = '0;
        end else if (pick_any) begin
          addr_d   = ch_addr[pick_idx];
          len_d    = ch_len[pick_idx];
          grant_d  = pick_grant;
          rr_ptr_d = pick_idx;
          tcnt_d   = '0;
          if (ch_len[pick_idx] == '0) begin
            state_d = ST_ZDONE;
          end else if (i_ch_we[pick_idx]) begin
            state_d    = ST_WRITE;
            wr_start_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            rd_start_d = 1'b1;
          end
        end
      end
      ST_REFRESH, ST_WRITE, ST_READ: begin
        if (eng_done && !start_now) begin
          done_d  = o_ch_grant;
          grant_d = '0;
          state_d = ST_ARB;
        end else if (tcnt_q == TCNT_LAST) begin
          // Engine hung: release the client and flag it until reset.
          err_d   = 1'b1;
          done_d  = o_ch_grant;
          grant_d = '0;
          state_d = ST_ARB;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_ZDONE: begin
        done_d  = o_ch_grant;
        grant_d = '0;
        state_d = ST_ARB;
      end
      default: begin
        state_d = ST_WAIT_INIT;
      end
    endcase

    busy_d = (state_d != ST_ARB);
  end

  // State and registered outputs.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state_q         <= ST_WAIT_INIT;
      rr_ptr_q        <= PW'(NUM_CH - 1);
      tcnt_q          <= '0;
      o_ch_grant      <= '0;
      o_ch_done       <= '0;
      o_refresh_start <= 1'b0;
      o_write_start   <= 1'b0;
      o_read_start    <= 1'b0;
      o_sel_addr      <= '0;
      o_sel_len       <= '0;
      o_busy          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      tcnt_q          <= tcnt_d;
      o_ch_grant      <= grant_d;
      o_ch_done       <= done_d;
      o_refresh_start <= ref_start_d;
      o_write_start   <= wr_start_d;
      o_read_start    <= rd_start_d;
      o_sel_addr      <= addr_d;
      o_sel_len       <= len_d;
      o_busy          <= busy_d;
      o_err           <= err_d;
    end
  end

endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// Self-checking bench for sdram_mport_arbiter: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_sdram_mport_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 24;
  localparam int unsigned LW  = 10;
  localparam int unsigned TMO = 16;

  logic              clk = 1'b0;
  logic              rst, init_done, ref_req, ref_done, wr_done, rd_done;
  logic [NCH-1:0]    ch_req, ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*LW-1:0] ch_len;
  logic [NCH-1:0]    o_ch_grant, o_ch_done;
  logic              o_refresh_start, o_write_start, o_read_start, o_busy, o_err;
  logic [AW-1:0]     o_sel_addr;
  logic [LW-1:0]     o_sel_len;

  always #5 clk = ~clk;

  sdram_mport_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO)) u_dut (
    .i_sysclk          (clk),
    .i_sysrst          (rst),
    .i_init_done       (init_done),
    .i_refresh_request (ref_req),
    .i_refresh_done    (ref_done),
    .i_wr_done         (wr_done),
    .i_rd_done         (rd_done),
    .i_ch_req          (ch_req),
    .i_ch_we           (ch_we),
    .i_ch_addr         (ch_addr),
    .i_ch_len          (ch_len),
    .o_ch_grant        (o_ch_grant),
    .o_ch_done         (o_ch_done),
    .o_refresh_start   (o_refresh_start),
    .o_write_start     (o_write_start),
    .o_read_start      (o_read_start),
    .o_sel_addr        (o_sel_addr),
    .o_sel_len         (o_sel_len),
    .o_busy            (o_busy),
    .o_err             (o_err)
  );

  int n_cmp, n_mis, cyc;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: what the arbiter is doing and what it owes.
  localparam int A_INIT = 0, A_IDLE = 1, A_REF = 2, A_WR = 3, A_RD = 4, A_ZERO = 5;
  int             m_act, m_last, m_age, m_chan;
  bit             m_err;
  logic [NCH-1:0] e_grant, e_done;
  bit             e_ref_st, e_wr_st, e_rd_st, e_busy;
  logic [AW-1:0]  e_addr;
  logic [LW-1:0]  e_len;

  task automatic finish_txn();
    e_done  = e_grant;
    e_grant = '0;
    m_act   = A_IDLE;
  endtask

  task automatic model_step();
    bit found, fin;
    e_done = '0; e_ref_st = 0; e_wr_st = 0; e_rd_st = 0;
    if (rst) begin
      m_act = A_INIT; m_last = NCH - 1; m_age = 0; m_err = 0;
      e_grant = '0; e_addr = '0; e_len = '0; e_busy = 0;
      return;
    end
    case (m_act)
      A_INIT: if (init_done) m_act = A_IDLE;
      A_IDLE: begin
        if (ref_req) begin
          m_act = A_REF; e_ref_st = 1; m_age = 0;
        end else if (ch_req != '0) begin
          found = 0;
          for (int d = 1; d <= NCH; d++) begin
            if (!found && ch_req[(m_last + d) % NCH]) begin
              m_chan = (m_last + d) % NCH;
              found  = 1;
            end
          end
          m_last  = m_chan;
          e_grant = NCH'(1) << m_chan;
          e_addr  = ch_addr[m_chan*AW +: AW];
          e_len   = ch_len[m_chan*LW +: LW];
          m_age   = 0;
          if (e_len == '0) m_act = A_ZERO;
          else if (ch_we[m_chan]) begin m_act = A_WR; e_wr_st = 1; end
          else begin m_act = A_RD; e_rd_st = 1; end
        end
      end
      A_REF, A_WR, A_RD: begin
        fin = (m_act == A_REF) ? ref_done : (m_act == A_WR) ? wr_done : rd_done;
        if (fin && m_age != 0) finish_txn();
        else if (m_age == TMO - 1) begin m_err = 1; finish_txn(); end
        else m_age++;
      end
      default: finish_txn();
    endcase
    e_busy = (m_act != A_IDLE);
  endtask

  // One clock: advance the model on the edge, then compare every output.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_val("grant",     o_ch_grant,      e_grant);
    check_val("ch_done",   o_ch_done,       e_done);
    check_val("ref_start", o_refresh_start, e_ref_st);
    check_val("wr_start",  o_write_start,   e_wr_st);
    check_val("rd_start",  o_read_start,    e_rd_st);
    check_val("sel_addr",  o_sel_addr,      e_addr);
    check_val("sel_len",   o_sel_len,       e_len);
    check_val("busy",      o_busy,          e_busy);
    check_val("err",       o_err,           m_err);
  endtask

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NCH; k++) if (v[k]) r = (r == -1) ? k : -2;
    return r;
  endfunction

  initial begin
    int t0, ng;
    int order [6];
    bit seen;
    n_cmp = 0; n_mis = 0; cyc = 0;
    rst = 1; init_done = 0; ref_req = 0; ref_done = 0; wr_done = 0; rd_done = 0;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_len = '0;
    repeat (2) cycle();

    // Requests before init must wait for init_done.
    rst = 0; ch_req = 4'b0001; ch_we = 4'b0001;
    ch_addr[AW-1:0] = 24'h123456; ch_len[LW-1:0] = 10'd16;
    repeat (5) cycle();
    check_val("pre_init_start", {o_write_start, o_read_start}, 0);
    init_done = 1; t0 = cyc; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin cycle(); seen = o_write_start; end
    check_val("init_lat", 64'(cyc - t0), 2);
    check_val("init_addr", o_sel_addr, 24'h123456);
    wr_done = 1; cycle();
    check_val("start_cyc_done_ignored", o_ch_grant, 4'b0001);
    cycle(); wr_done = 0;
    check_val("wr_done_pulse", o_ch_done, 4'b0001);
    ch_req = '0;

    // Round robin with four continuous readers, done 8 cycles after start.
    rst = 1; cycle(); rst = 0;
    ch_req = '1; ch_we = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_addr[k*AW +: AW] = AW'(32'h100000 * (k + 1));
      ch_len[k*LW +: LW]  = LW'(k + 3);
    end
    for (int i = 0; i < 6; i++) order[i] = -1;
    ng = 0;
    for (int i = 0; i < 300 && ng < 6; i++) begin
      rd_done = (m_act == A_RD && m_age == 8);
      cycle();
      if (o_read_start) begin order[ng] = onehot_idx(o_ch_grant); ng++; end
    end
    for (int i = 0; i < 6; i++) check_val("rr_order", 64'(order[i]), 64'(i % 4));
    ch_req = '0;
    for (int i = 0; i < 50 && m_act != A_IDLE; i++) begin
      rd_done = (m_act == A_RD && m_age == 8);
      cycle();
    end
    rd_done = 0;

    // Zero-length request completes without an engine start.
    ch_req = 4'b0010; ch_len[LW +: LW] = '0;
    cycle(); cycle();
    check_val("zlen_done", o_ch_done, 4'b0010);
    check_val("zlen_nostart", {o_write_start, o_read_start}, 0);
    ch_req = '0;
    cycle();

    // Refresh beats a simultaneous channel request.
    ref_req = 1; ch_req = 4'b0100; ch_we = 4'b0100;
    ch_len[2*LW +: LW] = 10'd5; ch_addr[2*AW +: AW] = 24'hABCDEF;
    cycle();
    check_val("ref_first", o_refresh_start, 1);
    check_val("ref_nogrant", o_ch_grant, 0);
    ref_req = 0;
    repeat (2) cycle();
    ref_done = 1; cycle(); ref_done = 0;
    check_val("ref_ret_nogrant", o_ch_grant, 0);
    cycle();
    check_val("ch2_grant", o_ch_grant, 4'b0100);

    // Refresh raised mid-write waits for the burst, then beats channel 3.
    ref_req = 1; ch_req = 4'b1100; ch_len[3*LW +: LW] = 10'd7; ch_addr[3*AW +: AW] = 24'h00BEEF;
    repeat (3) begin cycle(); check_val("no_ref_in_burst", o_refresh_start, 0); end
    wr_done = 1; cycle(); wr_done = 0;
    check_val("ch2_done", o_ch_done, 4'b0100);
    ch_req = 4'b1000;
    cycle();
    check_val("ref_before_ch3", o_refresh_start, 1);
    check_val("ref_before_ch3_grant", o_ch_grant, 0);
    ref_req = 0;
    cycle(); ref_done = 1; cycle(); ref_done = 0;

    // Channel 3 read with rd_done withheld must time out.
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin cycle(); seen = o_read_start; end
    t0 = cyc;
    for (int i = 0; i < 40 && o_ch_done == '0; i++) cycle();
    check_val("tmo_lat", 64'(cyc - t0), 16);
    check_val("tmo_done", o_ch_done, 4'b1000);
    check_val("tmo_err", o_err, 1);
    ch_req = '0;
    cycle();
    rst = 1; cycle(); rst = 0;
    check_val("rst_clears_err", o_err, 0);

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if (e_done[k]) ch_req[k] = 0;
        else if (!ch_req[k] && $urandom_range(0, 3) == 0) begin
          ch_req[k] = 1;
          ch_we[k]  = 1'($urandom_range(0, 1));
          ch_addr[k*AW +: AW] = AW'($urandom);
          ch_len[k*LW +: LW]  = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom);
        end else if (ch_req[k] && $urandom_range(0, 7) == 0) begin
          ch_addr[k*AW +: AW] = AW'($urandom);
          ch_len[k*LW +: LW]  = LW'($urandom);
        end
        if (e_grant[k] && $urandom_range(0, 31) == 0) ch_req[k] = 0;
      end
      if (e_ref_st) ref_req = 0;
      else if (!ref_req && $urandom_range(0, 39) == 0) ref_req = 1;
      ref_done = ($urandom_range(0, 3) == 0);
      wr_done  = ($urandom_range(0, 5) == 0);
      rd_done  = ($urandom_range(0, 5) == 0);
      if (!init_done) init_done = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (rst) init_done = 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
